// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
// Owner/state encodings and counter widths.
package wjbot_riscv;

  localparam int RUN_W = 4;
  localparam int TMO_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arbstate_t;

  typedef enum logic {
    OWN_CORE,
    OWN_DMA
  } arbowner_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection between core and DMA requesters.
// Core wins unless DMA waits and the core run limit is hit.
module arb_pick
  import wjbot_riscv::*;
(
  input  logic             c_req_i,
  input  logic             d_req_i,
  input  logic [RUN_W-1:0] run_cnt_i,
  input  logic [RUN_W-1:0] max_run_i,
  output arbowner_t        winner_o
);

  always_comb begin
    winner_o = OWN_CORE;
    if (d_req_i && (!c_req_i || run_cnt_i == max_run_i)) begin
      winner_o = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the unified core memory.
// IDLE -> ACCESS -> RESP, registered outputs, timeout abort.
module mem_arbiter
  import wjbot_riscv::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_CORE_RUN = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CORE_RUN);
  localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TIMEOUT);

  arbstate_t         state_q, state_d;
  arbowner_t         owner_q, owner_d;
  arbowner_t         winner;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mreq_q, mreq_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic              cack_q, cack_d;
  logic              dack_q, dack_d;
  logic [DATA_W-1:0] crdata_q, crdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              err_q, err_d;
  logic              rsp_v;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;

  arb_pick u_pick (
    .c_req_i   (c_req),
    .d_req_i   (d_req),
    .run_cnt_i (run_q),
    .max_run_i (RUN_MAX),
    .winner_o  (winner)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    run_d    = run_q;
    tmo_d    = tmo_q;
    mreq_d   = 1'b0;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rsp_v    = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (c_req || d_req) begin
          state_d = ARB_ACCESS;
          mreq_d  = 1'b1;
          owner_d = winner;
          tmo_d   = '0;
          if (winner == OWN_DMA) begin
            mwe_d    = d_we;
            maddr_d  = d_addr;
            mwdata_d = d_wdata;
            run_d    = '0;
          end else begin
            mwe_d    = c_we;
            maddr_d  = c_addr;
            mwdata_d = c_wdata;
            if (!d_req) run_d = '0;
            else if (run_q != RUN_MAX) run_d = run_q + 1'b1;
          end
        end
      end
      ARB_ACCESS: begin
        mreq_d = 1'b1;
        if (mem_ack) begin
          state_d  = ARB_RESP;
          mreq_d   = 1'b0;
          rsp_v    = 1'b1;
          rsp_data = mwe_q ? '0 : mem_rdata;
        end else begin
          tmo_d = tmo_q + 1'b1;
          // abort: deliver zero data flagged as error
          if (tmo_d == TMO_END) begin
            state_d = ARB_RESP;
            mreq_d  = 1'b0;
            rsp_v   = 1'b1;
            rsp_err = 1'b1;
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    cack_d   = rsp_v && owner_q == OWN_CORE;
    dack_d   = rsp_v && owner_q == OWN_DMA;
    crdata_d = cack_d ? rsp_data : '0;
    drdata_d = dack_d ? rsp_data : '0;
    err_d    = rsp_v && rsp_err;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_CORE;
      run_q    <= '0;
      tmo_q    <= '0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      cack_q   <= 1'b0;
      dack_q   <= 1'b0;
      crdata_q <= '0;
      drdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      run_q    <= run_d;
      tmo_q    <= tmo_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      cack_q   <= cack_d;
      dack_q   <= dack_d;
      crdata_q <= crdata_d;
      drdata_q <= drdata_d;
      err_q    <= err_d;
    end
  end

  assign mem_req   = mreq_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign c_ack     = cack_q;
  assign d_ack     = dack_q;
  assign c_rdata   = crdata_q;
  assign d_rdata   = drdata_q;
  assign err       = err_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle core between two requesters.
- Port C is the core's multicycle datapath and controller fetch/load/store; port D is the program-loader/DMA engine.
- Sequences each access through a registered request/acknowledge handshake toward memory and enforces a starvation bound on D.
- Aborts accesses the memory never acknowledges, and reports the abort.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_CORE_RUN, 4, max consecutive C grants while D is pending (1..15)
TIMEOUT, 64, cycles in ACCESS without mem_ack before abort (2..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
c_req  in  1  core access request; held with fields stable until c_ack
c_we  in  1  core write enable
c_addr  in  ADDR_W  core address
c_wdata  in  DATA_W  core write data
c_ack  out  1  one-cycle completion pulse to core
c_rdata  out  DATA_W  read data, valid while c_ack=1
d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  DMA request bundle, same rules as C
d_ack  out  1  one-cycle completion pulse to DMA
d_rdata  out  DATA_W  read data, valid while d_ack=1
mem_req  out  1  memory request; held until mem_ack or abort
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion; one-cycle pulse; ignored unless in ACCESS
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
err  out  1  one-cycle pulse coincident with the ack of an aborted access

Behaviour:
- Reset: reset==0 at a rising edge → state IDLE, owner=C, run counter=0, timeout counter=0. All outputs 0: c_ack, d_ack, c_rdata, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, err.
- Reset mid-access: mem_req drops the next cycle. No ack or err is issued. The memory must tolerate an abandoned request.
- FSM is IDLE → ACCESS → RESP → IDLE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Arbitration: C wins unless d_req=1 and run counter==MAX_CORE_RUN. If only one requester is asserting, it wins.
  - On grant: latch owner, we, addr, wdata into registers, reset the timeout counter, go to ACCESS.
  - C granted while d_req=1: run counter +1, saturating at MAX_CORE_RUN.
  - D granted, or C granted with d_req=0: run counter cleared.
- ACCESS:
  - mem_req=1, with mem_we/addr/wdata driven from the latched values.
  - mem_ack=1: capture mem_rdata, go to RESP.
  - Otherwise timeout counter +1. On reaching TIMEOUT: go to RESP with captured data=0 and an err flag set.
  - mem_ack and the timeout reached in the same cycle: mem_ack wins, no err.
- RESP (exactly 1 cycle):
  - mem_req=0. The owner's ack=1 and the owner's rdata=captured data.
  - err=flag. For writes, rdata=0.
  - Requests are not sampled in this cycle. Next state is IDLE.
- Latency: grant edge → mem_req high one cycle later. mem_ack → owner ack the following cycle. Minimum 3 cycles per access.
- Non-owner ack stays 0. rdata of the non-owner holds 0.
- Requests dropped before being granted are ignored. Requests dropped after grant still complete.
- Requester protocol violations (fields changing while req is held) have no effect after grant, because the fields are latched at grant.
- Outside ACCESS, mem_ack is ignored and causes no state change.
- Counter widths: run counter 4 bits, timeout counter 8 bits.

Decomposition:
- Add to package wjbot_riscv:
  - typedef enum logic [1:0] arbstate_t {ARB_IDLE, ARB_ACCESS, ARB_RESP}
  - typedef enum logic {OWN_CORE, OWN_DMA} arbowner_t
- One combinational sub-module, arb_pick: inputs c_req, d_req, run counter, MAX_CORE_RUN; output is the winner. Unit-testable in isolation.

Test Plan:
- Reset: hold reset=0 for 2 cycles during ACCESS with mem_req=1 → next cycle all outputs 0, state IDLE; no ack.
- Single core read: c_req=1, c_addr=0x100, c_we=0; memory acks 2 cycles after mem_req with rdata=0xDEADBEEF → mem_req seen 1 cycle after grant, mem_addr=0x100; c_ack=1 with c_rdata=0xDEADBEEF one cycle after mem_ack; d_ack stays 0.
- DMA write: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 → mem_we=1, mem_addr=0x40, mem_wdata=0x12345678; d_ack pulse one cycle after mem_ack; c_ack stays 0.
- Starvation bound: c_req and d_req both held continuously, MAX_CORE_RUN=4, memory acks immediately → grant order C,C,C,C,D,C,C,C,C,D.
- Timeout: c_req read at 0x200, memory never acks, TIMEOUT=64 → mem_req high 64 cycles, then c_ack=1, err=1, c_rdata=0 together; next request is served normally.
- Simultaneous ack/timeout and stray ack: mem_ack on the 64th ACCESS cycle → err=0 and data delivered; mem_ack pulse while IDLE → no ack, no state change.
